button_conditioner: RTL

// Conditions the five raw board pushbuttons before user_interface consumes them.
// Per button: 2-flop synchronizer, counter debounce, one-cycle press/release pulses, auto-repeat stream.

---
 rtl/button_conditioner_pkg.sv | 32 +++
 rtl/button_conditioner_btn_debounce.sv | 64 ++++++
 rtl/button_conditioner.sv | 110 +++++++++++
 3 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioning path: button bit
// positions, the system clock rate the default timings derive from, the
// auto-repeat state encoding and a counter-width helper.
package button_conditioner_pkg;

    localparam int CLK_HZ = 130_000_000;

    // Default timings: 5 ms debounce, 0.5 s repeat delay, 0.1 s repeat period.
    localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 200;
    localparam int REPEAT_DELAY_DEF    = CLK_HZ / 2;
    localparam int REPEAT_PERIOD_DEF   = CLK_HZ / 10;

    typedef logic [4:0] btn_vec_t;

    localparam int BTN_R = 0;
    localparam int BTN_L = 1;
    localparam int BTN_C = 2;
    localparam int BTN_D = 3;
    localparam int BTN_U = 4;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_conditioner_btn_debounce.sv
// One button bit: 2-flop synchronizer, counter debounce and registered
// press/release pulses that coincide with the debounced level change.
module btn_debounce
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    // Two-stage synchronizer for the asynchronous raw button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing cycles;
    // the counter clears at terminal count so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else if (sync_q == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_q <= sync_q;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Registered level plus one-cycle edge pulses aligned with the level change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            level         <= stable_q;
            press_pulse   <= stable_q & ~level;
            release_pulse <= ~stable_q & level;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton conditioner: per-button debounce with press/release pulses and
// an auto-repeat pulse stream. Define BTN_AUTOREPEAT_EN to build the repeat
// FSM; without it the repeat output simply mirrors the press pulse.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level_out,
    output logic [NUM_BTN-1:0] btn_press_out,
    output logic [NUM_BTN-1:0] btn_release_out,
    output logic [NUM_BTN-1:0] btn_repeat_out
);

    if (NUM_BTN < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
        $error("button_conditioner: NUM_BTN and all timing parameters must be >= 1");
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn

        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk          (clk_in),
            .rst_n        (rst_n_in),
            .raw          (btn_in[i]),
            .level        (btn_level_out[i]),
            .press_pulse  (btn_press_out[i]),
            .release_pulse(btn_release_out[i])
        );

`ifdef BTN_AUTOREPEAT_EN
        localparam int RCNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RCNT_W   = cnt_width(RCNT_MAX);
        localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
        localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

        rpt_state_t        state_q, state_d;
        logic [RCNT_W-1:0] rcnt_q, rcnt_d;
        logic              rpt;

        // Repeat FSM state and interval counter registers.
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                state_q <= RPT_IDLE;
                rcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
            end
        end

        // Next state and repeat pulse: pulse with the press, after the initial
        // delay, then every period; a release always returns to idle silently.
        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            rpt     = 1'b0;
            case (state_q)
                RPT_IDLE: begin
                    if (btn_press_out[i]) begin
                        rpt     = 1'b1;
                        state_d = RPT_DELAY;
                        rcnt_d  = '0;
                    end
                end
                RPT_DELAY: begin
                    if (rcnt_q == DELAY_LAST) begin
                        rpt     = 1'b1;
                        state_d = RPT_REPEAT;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (rcnt_q == PERIOD_LAST) begin
                        rpt    = 1'b1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = RPT_IDLE;
                    rcnt_d  = '0;
                end
            endcase
            if (btn_release_out[i]) begin
                state_d = RPT_IDLE;
                rcnt_d  = '0;
                rpt     = 1'b0;
            end
        end

        assign btn_repeat_out[i] = rpt;
`endif
    end

`ifndef BTN_AUTOREPEAT_EN
    assign btn_repeat_out = btn_press_out;
`endif

endmodule
